// File: rtl/load_writeback_pkg.sv
// Shared definitions for the load/writeback stage: load funct3 encodings, FSM states and
// small decode helpers.
package load_writeback_pkg;

  localparam logic [2:0] Funct3Lb  = 3'b000;
  localparam logic [2:0] Funct3Lh  = 3'b001;
  localparam logic [2:0] Funct3Lw  = 3'b010;
  localparam logic [2:0] Funct3Lbu = 3'b100;
  localparam logic [2:0] Funct3Lhu = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StWb
  } lwb_state_e;

  function automatic logic is_half(input logic [2:0] funct3);
    return (funct3 == Funct3Lh) || (funct3 == Funct3Lhu);
  endfunction

  // Unused encodings 011/110/111 behave as a full-word load.
  function automatic logic is_word(input logic [2:0] funct3);
    return !((funct3 == Funct3Lb) || (funct3 == Funct3Lh) ||
             (funct3 == Funct3Lbu) || (funct3 == Funct3Lhu));
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    return (is_half(funct3) && off[0]) || (is_word(funct3) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/load_writeback_align.sv
// load_align: selects the addressed byte/halfword from a read word and sign- or
// zero-extends it according to funct3.
module load_align
  import load_writeback_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{off, 3'b000} +: 8];
    half_sel = off[1] ? word[31:16] : word[15:0];
    case (funct3)
      Funct3Lb:  result = {{24{byte_sel[7]}}, byte_sel};
      Funct3Lh:  result = {{16{half_sel[15]}}, half_sel};
      Funct3Lbu: result = {24'h000000, byte_sel};
      Funct3Lhu: result = {16'h0000, half_sel};
      default:   result = word;
    endcase
  end

endmodule

// File: rtl/load_writeback.sv
// Load/writeback stage: forwards non-load results to the register file and runs a
// REQ/WAIT/WB cache read for loads. Optional macro LOAD_WB_MISALIGN_CHECK_EN adds misalign.
module load_writeback
  import load_writeback_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic            ex_is_load,
  input  logic            ex_regwrite,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_result,
  input  logic [2:0]      ex_funct3,
  output logic            dc_req,
  output logic [XLEN-1:0] dc_addr,
  input  logic            dc_ack,
  input  logic            dc_rvalid,
  input  logic [XLEN-1:0] dc_rdata,
  output logic            Regwrite,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] WD3,
  output logic            busy
`ifdef LOAD_WB_MISALIGN_CHECK_EN
  ,
  output logic            misalign
`endif
);

  lwb_state_e state_q;
  logic [4:0] ld_rd_q;
  logic [2:0] ld_funct3_q;
  logic [1:0] ld_off_q;
  logic [31:0] aligned;
  logic load_reject;

  assign ex_ready = (state_q == StIdle);

`ifdef LOAD_WB_MISALIGN_CHECK_EN
  assign load_reject = is_misaligned(ex_funct3, ex_result[1:0]);
`else
  assign load_reject = 1'b0;
`endif

  load_align u_load_align (
    .word   (dc_rdata),
    .off    (ld_off_q),
    .funct3 (ld_funct3_q),
    .result (aligned)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      Regwrite    <= 1'b0;
      rd          <= '0;
      WD3         <= '0;
      dc_req      <= 1'b0;
      dc_addr     <= '0;
      busy        <= 1'b0;
      ld_rd_q     <= '0;
      ld_funct3_q <= '0;
      ld_off_q    <= '0;
`ifdef LOAD_WB_MISALIGN_CHECK_EN
      misalign    <= 1'b0;
`endif
    end else begin
      Regwrite <= 1'b0;
`ifdef LOAD_WB_MISALIGN_CHECK_EN
      misalign <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (ex_valid) begin
            if (ex_is_load) begin
              if (load_reject) begin
`ifdef LOAD_WB_MISALIGN_CHECK_EN
                misalign <= 1'b1;
`endif
              end else begin
                ld_rd_q     <= ex_rd;
                ld_funct3_q <= ex_funct3;
                ld_off_q    <= ex_result[1:0];
                dc_req      <= 1'b1;
                dc_addr     <= {ex_result[XLEN-1:2], 2'b00};
                busy        <= 1'b1;
                state_q     <= StReq;
              end
            end else if (ex_regwrite && (ex_rd != 5'd0)) begin
              Regwrite <= 1'b1;
              rd       <= ex_rd;
              WD3      <= ex_result;
            end
          end
        end
        StReq: begin
          if (dc_ack) begin
            dc_req  <= 1'b0;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (dc_rvalid) begin
            // x0 loads still complete the cache access but never write.
            if (ld_rd_q != 5'd0) begin
              Regwrite <= 1'b1;
              rd       <= ld_rd_q;
              WD3      <= aligned;
            end
            state_q <= StWb;
          end
        end
        StWb: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_load_writeback.sv
// Self-checking bench for load_writeback: directed vectors, a queue-based writeback model
// and a per-cycle compare process.
module tb_load_writeback;
  import load_writeback_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic        ex_is_load = 1'b0;
  logic        ex_regwrite = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic [31:0] ex_result = '0;
  logic [2:0]  ex_funct3 = '0;
  logic        dc_req;
  logic [31:0] dc_addr;
  logic        dc_ack = 1'b0;
  logic        dc_rvalid = 1'b0;
  logic [31:0] dc_rdata = '0;
  logic        Regwrite;
  logic [4:0]  rd;
  logic [31:0] WD3;
  logic        busy;
`ifdef LOAD_WB_MISALIGN_CHECK_EN
  logic        misalign;
`endif

  load_writeback #(.XLEN(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_is_load  (ex_is_load),
    .ex_regwrite (ex_regwrite),
    .ex_rd       (ex_rd),
    .ex_result   (ex_result),
    .ex_funct3   (ex_funct3),
    .dc_req      (dc_req),
    .dc_addr     (dc_addr),
    .dc_ack      (dc_ack),
    .dc_rvalid   (dc_rvalid),
    .dc_rdata    (dc_rdata),
    .Regwrite    (Regwrite),
    .rd          (rd),
    .WD3         (WD3),
    .busy        (busy)
`ifdef LOAD_WB_MISALIGN_CHECK_EN
    ,
    .misalign    (misalign)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic        started = 1'b0;
  logic        rst_seen = 1'b0;
  logic [4:0]  model_rd = '0;
  logic [31:0] model_wd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected load result from plain address arithmetic.
  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] a,
                                             input logic [2:0] f3);
    int unsigned b;
    int unsigned h;
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'b001:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  always @(posedge clock) rst_seen <= reset;

  always @(negedge clock) begin
    if (started) begin
      if (rst_seen) begin
        model_rd = '0;
        model_wd = '0;
        chk("reset_regwrite", {31'd0, Regwrite}, 32'd0);
        chk("reset_rd", {27'd0, rd}, 32'd0);
        chk("reset_wd3", WD3, 32'd0);
      end else if (Regwrite === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: rd=%0d WD3=%h expected no write at %0t", rd, WD3,
                   $time);
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          model_rd = w.rd;
          model_wd = w.data;
          chk("write_rd", {27'd0, rd}, {27'd0, w.rd});
          chk("write_wd3", WD3, w.data);
        end
      end else begin
        chk("regwrite_idle", {31'd0, Regwrite}, 32'd0);
        chk("rd_hold", {27'd0, rd}, {27'd0, model_rd});
        chk("wd3_hold", WD3, model_wd);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (ex_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: ex_ready=%b expected 1", ex_ready);
    end
  endtask

  task automatic issue(input logic is_load, input logic rw, input logic [4:0] r,
                       input logic [31:0] res, input logic [2:0] f3);
    wait_ready();
    ex_valid    = 1'b1;
    ex_is_load  = is_load;
    ex_regwrite = rw;
    ex_rd       = r;
    ex_result   = res;
    ex_funct3   = f3;
    if (!is_load && rw && r != 5'd0) exp_q.push_back('{r, res});
    tick();
    ex_valid    = 1'b0;
    ex_is_load  = 1'b0;
    ex_regwrite = 1'b0;
  endtask

  // Serves one cache read; stray rvalid during the request phase must be ignored.
  task automatic serve(input logic [31:0] addr, input int ack_delay, input int rv_delay,
                       input logic [31:0] word, input logic [4:0] r, input logic [2:0] f3);
    int n = 0;
    logic [31:0] exp_addr;
    exp_addr = addr & 32'hFFFF_FFFC;
    while (dc_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL dc_req_timeout: dc_req=%b expected 1", dc_req);
    end
    chk("dc_addr", dc_addr, exp_addr);
    for (int i = 0; i < ack_delay; i++) begin
      dc_rvalid = 1'b1;
      dc_rdata  = 32'hFFFF_FFFF;
      tick();
      chk("dc_req_held", {31'd0, dc_req}, 32'd1);
      chk("dc_addr_held", dc_addr, exp_addr);
      chk("ready_low_busy", {31'd0, ex_ready}, 32'd0);
    end
    dc_rvalid = 1'b0;
    dc_ack    = 1'b1;
    tick();
    dc_ack = 1'b0;
    chk("dc_req_drop", {31'd0, dc_req}, 32'd0);
    for (int i = 0; i < rv_delay; i++) tick();
    if (r != 5'd0) exp_q.push_back('{r, model_load(word, addr, f3)});
    dc_rvalid = 1'b1;
    dc_rdata  = word;
    tick();
    dc_rvalid = 1'b0;
    dc_rdata  = '0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] word;
    logic [4:0]  r;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8] = '{
    '{32'h0000_0101, 3'b100, 32'h0000_80FF, 5'd8,  32'h0000_0080},
    '{32'h0000_0200, 3'b001, 32'h0000_8001, 5'd9,  32'hFFFF_8001},
    '{32'h0000_0300, 3'b010, 32'hCAFE_F00D, 5'd10, 32'hCAFE_F00D},
    '{32'h0000_0304, 3'b011, 32'h0123_4567, 5'd11, 32'h0123_4567},
    '{32'h0000_0308, 3'b110, 32'h89AB_CDEF, 5'd12, 32'h89AB_CDEF},
    '{32'h0000_030C, 3'b111, 32'h55AA_55AA, 5'd13, 32'h55AA_55AA},
    '{32'h0000_0102, 3'b000, 32'h007F_0000, 5'd14, 32'h0000_007F},
    '{32'h0000_0206, 3'b101, 32'h8001_0000, 5'd15, 32'h0000_8001}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    tick();
    started = 1'b1;
    tick();
    chk("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_dc_req", {31'd0, dc_req}, 32'd0);
    chk("rst_dc_addr", dc_addr, 32'd0);
    chk("rst_wd3", WD3, 32'd0);
    reset = 1'b0;
    tick();

    // Non-load write
    issue(1'b0, 1'b1, 5'd5, 32'h0000_1234, 3'b000);
    chk("nl_regwrite", {31'd0, Regwrite}, 32'd1);
    chk("nl_rd", {27'd0, rd}, 32'd5);
    chk("nl_wd3", WD3, 32'h0000_1234);
    chk("nl_busy", {31'd0, busy}, 32'd0);
    issue(1'b0, 1'b0, 5'd9, 32'hAAAA_0000, 3'b000);
    issue(1'b0, 1'b1, 5'd0, 32'hBBBB_0000, 3'b000);
    issue(1'b0, 1'b1, 5'd31, 32'h8000_0001, 3'b000);
    tick();

    // LB sign extension from the top byte
    issue(1'b1, 1'b0, 5'd3, 32'h0000_0103, Funct3Lb);
    serve(32'h0000_0103, 0, 1, 32'h80FF_0000, 5'd3, Funct3Lb);
    chk("lb_regwrite", {31'd0, Regwrite}, 32'd1);
    chk("lb_wd3", WD3, 32'hFFFF_FF80);

    // LHU with a slow ack
    issue(1'b1, 1'b0, 5'd4, 32'h0000_0202, Funct3Lhu);
    serve(32'h0000_0202, 3, 0, 32'hBEEF_1234, 5'd4, Funct3Lhu);
    chk("lhu_wd3", WD3, 32'h0000_BEEF);

    // LW to x0: handshake completes, no write
    issue(1'b1, 1'b0, 5'd0, 32'h0000_0400, Funct3Lw);
    serve(32'h0000_0400, 1, 2, 32'hDEAD_BEEF, 5'd0, Funct3Lw);
    chk("x0_regwrite", {31'd0, Regwrite}, 32'd0);
    tick();
    chk("x0_idle", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      issue(1'b1, 1'b0, vecs[i].r, vecs[i].addr, vecs[i].f3);
      serve(vecs[i].addr, i % 3, i % 2, vecs[i].word, vecs[i].r, vecs[i].f3);
      chk("vec_wd3", WD3, vecs[i].exp);
    end

    // Reset while waiting for read data, then a late rvalid
    issue(1'b1, 1'b0, 5'd7, 32'h0000_0500, Funct3Lw);
    dc_ack = 1'b1;
    tick();
    dc_ack = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    dc_rvalid = 1'b1;
    dc_rdata  = 32'h1111_1111;
    tick();
    dc_rvalid = 1'b0;
    chk("abort_regwrite", {31'd0, Regwrite}, 32'd0);
    chk("abort_ready", {31'd0, ex_ready}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    tick();

    // Misaligned halfword
`ifdef LOAD_WB_MISALIGN_CHECK_EN
    issue(1'b1, 1'b0, 5'd6, 32'h0000_0101, Funct3Lh);
    chk("mis_pulse", {31'd0, misalign}, 32'd1);
    chk("mis_no_req", {31'd0, dc_req}, 32'd0);
    chk("mis_idle", {31'd0, busy}, 32'd0);
    tick();
    chk("mis_one_cycle", {31'd0, misalign}, 32'd0);
    chk("mis_no_req2", {31'd0, dc_req}, 32'd0);
    issue(1'b1, 1'b0, 5'd6, 32'h0000_0102, Funct3Lw);
    chk("mis_lw_pulse", {31'd0, misalign}, 32'd1);
    chk("mis_lw_no_req", {31'd0, dc_req}, 32'd0);
    tick();
`else
    issue(1'b1, 1'b0, 5'd6, 32'h0000_0101, Funct3Lh);
    serve(32'h0000_0101, 0, 0, 32'h1234_8765, 5'd6, Funct3Lh);
    chk("mis_lh_wd3", WD3, 32'hFFFF_8765);
    tick();
`endif

    issue(1'b0, 1'b1, 5'd2, 32'h0BAD_CAFE, 3'b000);
    tick();
    tick();
    chk("pending_writes", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
